pulse_feature_extractor: RTL and testbench

- Parametrised, single-pass successor to the fixed-width monopulse extraction and arithmetic pair.
- Detects pulses in a streaming ADC sample stream against a programmable threshold.
- Accumulates per-pulse features on the fly without buffering samples: length, position, peak, front/behind/total area, sum of squares.
- Presents each feature record through a valid/ready output register to the downstream classifier or DDR2 writer.

---
 rtl/pulse_feature_pkg.sv | 44 ++++
 rtl/pulse_feature_accum.sv | 95 +++++++++
 rtl/pulse_feature_extractor.sv | 178 +++++++++++++++++
 tb/tb_pulse_feature_extractor.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_feature_pkg.sv
// Shared state, record type and width helpers for the pulse feature extractor.
// The record struct is laid out for the package default widths.
package pulse_feature_pkg;

   localparam int PF_DATA_W = 8;
   localparam int PF_CNT_W  = 16;
   localparam int PF_POS_W  = 32;

   function automatic int area_w(input int dw, input int cw);
      return dw + cw;
   endfunction

   function automatic int sq_w(input int dw, input int cw);
      return 2 * dw + cw;
   endfunction

   function automatic int cube_w(input int dw, input int cw);
      return 3 * dw + cw;
   endfunction

   localparam int PF_AREA_W = area_w(PF_DATA_W, PF_CNT_W);
   localparam int PF_SQ_W   = sq_w(PF_DATA_W, PF_CNT_W);
   localparam int PF_CUBE_W = cube_w(PF_DATA_W, PF_CNT_W);

   typedef enum logic [1:0] {
      IDLE,
      IN_PULSE,
      WAIT_LOW
   } state_t;

   typedef struct packed {
      logic [PF_CNT_W-1:0]  len;
      logic [PF_POS_W-1:0]  pos;
      logic [PF_DATA_W-1:0] peak;
      logic [PF_CNT_W-1:0]  idx;
      logic [PF_AREA_W-1:0] front;
      logic [PF_AREA_W-1:0] behind;
      logic [PF_AREA_W-1:0] total;
      logic [PF_SQ_W-1:0]   sq;
      logic [PF_CUBE_W-1:0] cube;
      logic                 truncated;
   } feat_rec_t;

endpackage

// File: rtl/pulse_feature_accum.sv
// Per-pulse running accumulators: length, position, peak, areas and powers.
// PULSE_FEATURE_CUBE_EN adds the third-power accumulator.
module pulse_feature_accum
   import pulse_feature_pkg::*;
#(
   parameter int DATA_W = PF_DATA_W,
   parameter int CNT_W  = PF_CNT_W,
   parameter int POS_W  = PF_POS_W
) (
   input  logic                              Clk,
   input  logic                              Rst,
   input  logic                              start,
   input  logic                              step,
   input  logic                              clear,
   input  logic [DATA_W-1:0]                 sample,
   input  logic [POS_W-1:0]                  sample_pos,
   output logic [CNT_W-1:0]                  len,
   output logic [POS_W-1:0]                  pos,
   output logic [DATA_W-1:0]                 peak,
   output logic [CNT_W-1:0]                  idx,
   output logic [area_w(DATA_W,CNT_W)-1:0]   front,
   output logic [area_w(DATA_W,CNT_W)-1:0]   total,
   output logic [sq_w(DATA_W,CNT_W)-1:0]     sq,
   output logic [cube_w(DATA_W,CNT_W)-1:0]   cube
);

   localparam int AW = area_w(DATA_W, CNT_W);
   localparam int SW = sq_w(DATA_W, CNT_W);

   logic [AW-1:0] x_a;
   logic [SW-1:0] x_sq;

   assign x_a  = AW'(sample);
   assign x_sq = SW'(sample) * SW'(sample);

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         len   <= '0;
         pos   <= '0;
         peak  <= '0;
         idx   <= '0;
         front <= '0;
         total <= '0;
         sq    <= '0;
      end else if (clear) begin
         len   <= '0;
         pos   <= '0;
         peak  <= '0;
         idx   <= '0;
         front <= '0;
         total <= '0;
         sq    <= '0;
      end else if (start) begin
         len   <= CNT_W'(1);
         pos   <= sample_pos;
         peak  <= sample;
         idx   <= '0;
         front <= x_a;
         total <= x_a;
         sq    <= x_sq;
      end else if (step) begin
         len   <= len + CNT_W'(1);
         total <= total + x_a;
         sq    <= sq + x_sq;
         // strict compare keeps the first of equal peaks
         if (sample > peak) begin
            peak  <= sample;
            idx   <= len;
            front <= total + x_a;
         end
      end
   end

`ifdef PULSE_FEATURE_CUBE_EN
   localparam int CW = cube_w(DATA_W, CNT_W);

   logic [CW-1:0] x_cu;

   assign x_cu = CW'(sample) * CW'(sample) * CW'(sample);

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst)
         cube <= '0;
      else if (clear)
         cube <= '0;
      else if (start)
         cube <= x_cu;
      else if (step)
         cube <= cube + x_cu;
   end
`else
   assign cube = '0;
`endif

endmodule

// File: rtl/pulse_feature_extractor.sv
// Streaming pulse detector with on-the-fly feature record and valid/ready output.
// PULSE_FEATURE_CUBE_EN enables the Sum_cube accumulator.
module pulse_feature_extractor
   import pulse_feature_pkg::*;
#(
   parameter int DATA_W  = PF_DATA_W,
   parameter int CNT_W   = PF_CNT_W,
   parameter int POS_W   = PF_POS_W,
   parameter int MAX_LEN = 1024
) (
   input  logic                              Clk,
   input  logic                              Rst,
   input  logic                              Extract_en,
   input  logic                              Sample_valid,
   input  logic [DATA_W-1:0]                 Sample_data,
   input  logic [POS_W-1:0]                  Sample_pos,
   input  logic [DATA_W-1:0]                 Threshold,
   input  logic [CNT_W-1:0]                  Min_len,
   output logic                              Feature_valid,
   input  logic                              Feature_ready,
   output logic [CNT_W-1:0]                  Pulse_len,
   output logic [POS_W-1:0]                  Pulse_pos,
   output logic [DATA_W-1:0]                 Peak_value,
   output logic [CNT_W-1:0]                  Peak_index,
   output logic [area_w(DATA_W,CNT_W)-1:0]   Front_area,
   output logic [area_w(DATA_W,CNT_W)-1:0]   Behind_area,
   output logic [area_w(DATA_W,CNT_W)-1:0]   Total_area,
   output logic [sq_w(DATA_W,CNT_W)-1:0]     Sum_sq,
   output logic [cube_w(DATA_W,CNT_W)-1:0]   Sum_cube,
   output logic                              Truncated,
   output logic [CNT_W-1:0]                  Pulse_count,
   output logic [CNT_W-1:0]                  Drop_count,
   output logic                              Busy
);

   localparam int AW = area_w(DATA_W, CNT_W);
   localparam int SW = sq_w(DATA_W, CNT_W);
   localparam int CW = cube_w(DATA_W, CNT_W);

   state_t            state;
   feat_rec_t         rec;
   logic              consume;
   logic              hit;
   logic              start;
   logic              step;
   logic              clear;
   logic              close;
   logic              trunc;
   logic              keep;
   logic              load;
   logic              hs;
   logic [CNT_W-1:0]  a_len;
   logic [POS_W-1:0]  a_pos;
   logic [DATA_W-1:0] a_peak;
   logic [CNT_W-1:0]  a_idx;
   logic [AW-1:0]     a_front;
   logic [AW-1:0]     a_total;
   logic [SW-1:0]     a_sq;
   logic [CW-1:0]     a_cube;

   assign consume = Sample_valid & Extract_en;
   assign hit     = Sample_data >= Threshold;

   always_comb begin
      start = 1'b0;
      step  = 1'b0;
      clear = 1'b0;
      close = 1'b0;
      trunc = 1'b0;
      unique case (state)
         IDLE: start = consume & hit;
         IN_PULSE: begin
            if (!Extract_en) begin
               clear = 1'b1;
            end else if (Sample_valid) begin
               if (!hit) begin
                  close = 1'b1;
               end else if (a_len < CNT_W'(MAX_LEN)) begin
                  step = 1'b1;
               end else begin
                  close = 1'b1;
                  trunc = 1'b1;
               end
            end
         end
         WAIT_LOW: clear = ~Extract_en;
         default: ;
      endcase
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state <= IDLE;
      end else begin
         unique case (state)
            IDLE:
               if (start) state <= IN_PULSE;
            IN_PULSE:
               if (clear || (close && !trunc)) state <= IDLE;
               else if (trunc) state <= WAIT_LOW;
            WAIT_LOW:
               if (clear || (consume && !hit)) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   pulse_feature_accum #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W),
      .POS_W  (POS_W)
   ) u_accum (
      .Clk        (Clk),
      .Rst        (Rst),
      .start      (start),
      .step       (step),
      .clear      (clear),
      .sample     (Sample_data),
      .sample_pos (Sample_pos),
      .len        (a_len),
      .pos        (a_pos),
      .peak       (a_peak),
      .idx        (a_idx),
      .front      (a_front),
      .total      (a_total),
      .sq         (a_sq),
      .cube       (a_cube)
   );

   // a handshake this cycle frees the register for the new record
   assign keep = close & (a_len >= Min_len);
   assign hs   = Feature_valid & Feature_ready;
   assign load = keep & (~Feature_valid | Feature_ready);

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         Feature_valid <= 1'b0;
         rec           <= '0;
         Pulse_count   <= '0;
         Drop_count    <= '0;
      end else begin
         if (hs)
            Pulse_count <= Pulse_count + CNT_W'(1);
         if (load) begin
            Feature_valid <= 1'b1;
            rec <= '{
               len:       a_len,
               pos:       a_pos,
               peak:      a_peak,
               idx:       a_idx,
               front:     a_front,
               behind:    a_total - a_front,
               total:     a_total,
               sq:        a_sq,
               cube:      a_cube,
               truncated: trunc
            };
         end else if (hs) begin
            Feature_valid <= 1'b0;
         end
         if (keep && !load && !(&Drop_count))
            Drop_count <= Drop_count + CNT_W'(1);
      end
   end

   assign Pulse_len   = rec.len;
   assign Pulse_pos   = rec.pos;
   assign Peak_value  = rec.peak;
   assign Peak_index  = rec.idx;
   assign Front_area  = rec.front;
   assign Behind_area = rec.behind;
   assign Total_area  = rec.total;
   assign Sum_sq      = rec.sq;
   assign Sum_cube    = rec.cube;
   assign Truncated   = rec.truncated;
   assign Busy        = (state == IN_PULSE);

endmodule

// File: tb/tb_pulse_feature_extractor.sv
// Scoreboard bench for pulse_feature_extractor (MAX_LEN=4 build).
// Expected Sum_cube follows PULSE_FEATURE_CUBE_EN.
module tb_pulse_feature_extractor;

`ifdef PULSE_FEATURE_CUBE_EN
   localparam bit CUBE = 1'b1;
`else
   localparam bit CUBE = 1'b0;
`endif

   logic        Clk = 1'b0;
   logic        Rst;
   logic        Extract_en;
   logic        Sample_valid;
   logic [7:0]  Sample_data;
   logic [31:0] Sample_pos;
   logic [7:0]  Threshold;
   logic [15:0] Min_len;
   logic        Feature_valid;
   logic        Feature_ready;
   logic [15:0] Pulse_len;
   logic [31:0] Pulse_pos;
   logic [7:0]  Peak_value;
   logic [15:0] Peak_index;
   logic [23:0] Front_area;
   logic [23:0] Behind_area;
   logic [23:0] Total_area;
   logic [31:0] Sum_sq;
   logic [39:0] Sum_cube;
   logic        Truncated;
   logic [15:0] Pulse_count;
   logic [15:0] Drop_count;
   logic        Busy;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [63:0] len;
      logic [63:0] pos;
      logic [63:0] peak;
      logic [63:0] idx;
      logic [63:0] front;
      logic [63:0] behind;
      logic [63:0] total;
      logic [63:0] sq;
      logic [63:0] cube;
      logic        tr;
   } rec_t;

   rec_t exp_q[$];
   rec_t e;

   pulse_feature_extractor #(
      .DATA_W  (8),
      .CNT_W   (16),
      .POS_W   (32),
      .MAX_LEN (4)
   ) dut (
      .Clk           (Clk),
      .Rst           (Rst),
      .Extract_en    (Extract_en),
      .Sample_valid  (Sample_valid),
      .Sample_data   (Sample_data),
      .Sample_pos    (Sample_pos),
      .Threshold     (Threshold),
      .Min_len       (Min_len),
      .Feature_valid (Feature_valid),
      .Feature_ready (Feature_ready),
      .Pulse_len     (Pulse_len),
      .Pulse_pos     (Pulse_pos),
      .Peak_value    (Peak_value),
      .Peak_index    (Peak_index),
      .Front_area    (Front_area),
      .Behind_area   (Behind_area),
      .Total_area    (Total_area),
      .Sum_sq        (Sum_sq),
      .Sum_cube      (Sum_cube),
      .Truncated     (Truncated),
      .Pulse_count   (Pulse_count),
      .Drop_count    (Drop_count),
      .Busy          (Busy)
   );

   always #5 Clk = ~Clk;

   function automatic void chk(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   function automatic void push(input longint len, input longint pos,
                                input longint peak, input longint idx,
                                input longint front, input longint behind,
                                input longint total, input longint sq,
                                input longint cube, input bit tr);
      rec_t r;
      r.len    = 64'(len);
      r.pos    = 64'(pos);
      r.peak   = 64'(peak);
      r.idx    = 64'(idx);
      r.front  = 64'(front);
      r.behind = 64'(behind);
      r.total  = 64'(total);
      r.sq     = 64'(sq);
      r.cube   = CUBE ? 64'(cube) : 64'd0;
      r.tr     = tr;
      exp_q.push_back(r);
   endfunction

   // monitor: every accepted record is checked against the queue head
   always @(negedge Clk) begin
      if (!Rst && Feature_valid && Feature_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_record: got len %0d pos %0d, expected none",
                     Pulse_len, Pulse_pos);
         end else begin
            e = exp_q.pop_front();
            chk("len", 64'(Pulse_len), e.len);
            chk("pos", 64'(Pulse_pos), e.pos);
            chk("peak", 64'(Peak_value), e.peak);
            chk("idx", 64'(Peak_index), e.idx);
            chk("front", 64'(Front_area), e.front);
            chk("behind", 64'(Behind_area), e.behind);
            chk("total", 64'(Total_area), e.total);
            chk("sum_sq", 64'(Sum_sq), e.sq);
            chk("sum_cube", 64'(Sum_cube), e.cube);
            chk("truncated", 64'(Truncated), 64'(e.tr));
         end
      end
   end

   task automatic send(input logic [7:0] d, input logic [31:0] p);
      Sample_valid = 1'b1;
      Sample_data  = d;
      Sample_pos   = p;
      @(posedge Clk);
      #1;
      Sample_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge Clk);
         #1;
      end
   endtask

   initial begin
      Rst           = 1'b1;
      Extract_en    = 1'b1;
      Sample_valid  = 1'b0;
      Sample_data   = '0;
      Sample_pos    = '0;
      Threshold     = 8'd10;
      Min_len       = 16'd2;
      Feature_ready = 1'b1;
      idle(2);
      chk("rst_valid", 64'(Feature_valid), 0);
      chk("rst_busy", 64'(Busy), 0);
      chk("rst_pcount", 64'(Pulse_count), 0);
      chk("rst_total", 64'(Total_area), 0);
      Rst = 1'b0;
      idle(2);

      // basic pulse and one-cycle latency
      push(3, 101, 30, 1, 42, 20, 62, 1444, 36728, 0);
      send(8'd0, 100);
      send(8'd12, 101);
      send(8'd30, 102);
      send(8'd20, 103);
      @(negedge Clk);
      chk("lat_before", 64'(Feature_valid), 0);
      chk("busy_in_pulse", 64'(Busy), 1);
      send(8'd5, 104);
      @(negedge Clk);
      chk("lat_after", 64'(Feature_valid), 1);
      idle(2);

      // equal peaks keep the first
      push(3, 201, 20, 0, 20, 35, 55, 1025, 19375, 0);
      send(8'd0, 200);
      send(8'd20, 201);
      send(8'd20, 202);
      send(8'd15, 203);
      send(8'd0, 204);
      idle(2);

      // short pulse is discarded
      Min_len = 16'd3;
      send(8'd0, 250);
      send(8'd15, 251);
      send(8'd15, 252);
      send(8'd0, 253);
      @(negedge Clk);
      chk("short_valid", 64'(Feature_valid), 0);
      idle(2);
      chk("short_pcount", 64'(Pulse_count), 2);
      Min_len = 16'd2;

      // full output register drops the second record
      Feature_ready = 1'b0;
      push(2, 300, 40, 0, 40, 40, 80, 3200, 128000, 0);
      send(8'd40, 300);
      send(8'd40, 301);
      send(8'd0, 302);
      send(8'd60, 303);
      send(8'd70, 304);
      send(8'd0, 305);
      @(negedge Clk);
      chk("drop_count", 64'(Drop_count), 1);
      chk("held_valid", 64'(Feature_valid), 1);
      chk("held_len", 64'(Pulse_len), 2);
      chk("held_peak", 64'(Peak_value), 40);
      chk("held_pos", 64'(Pulse_pos), 300);
      idle(1);
      Feature_ready = 1'b1;
      idle(3);
      chk("pcount_after_drop", 64'(Pulse_count), 3);

      // forced close at MAX_LEN, then wait for a low sample
      push(4, 400, 50, 0, 50, 150, 200, 10000, 500000, 1);
      for (int i = 0; i < 6; i++)
         send(8'd50, 32'(400 + i));
      send(8'd0, 406);
      @(negedge Clk);
      chk("trunc_busy", 64'(Busy), 0);
      chk("trunc_single", 64'(Feature_valid), 0);
      push(2, 407, 26, 1, 51, 0, 51, 1301, 33201, 0);
      send(8'd25, 407);
      send(8'd26, 408);
      send(8'd3, 409);
      idle(2);

      // Extract_en low aborts the open pulse
      send(8'd0, 500);
      send(8'd30, 501);
      send(8'd31, 502);
      Extract_en = 1'b0;
      idle(1);
      @(negedge Clk);
      chk("abort_busy", 64'(Busy), 0);
      Extract_en = 1'b1;
      idle(1);
      push(2, 510, 12, 1, 23, 0, 23, 265, 3059, 0);
      send(8'd11, 510);
      send(8'd12, 511);
      send(8'd0, 512);
      idle(2);

      // asynchronous reset with a held record and an open pulse
      Feature_ready = 1'b0;
      send(8'd40, 600);
      send(8'd41, 601);
      send(8'd0, 602);
      send(8'd40, 603);
      chk("pre_rst_busy", 64'(Busy), 1);
      chk("pre_rst_valid", 64'(Feature_valid), 1);
      #2;
      Rst = 1'b1;
      #1;
      chk("arst_valid", 64'(Feature_valid), 0);
      chk("arst_busy", 64'(Busy), 0);
      chk("arst_pcount", 64'(Pulse_count), 0);
      chk("arst_dcount", 64'(Drop_count), 0);
      chk("arst_len", 64'(Pulse_len), 0);
      chk("arst_total", 64'(Total_area), 0);
      idle(1);
      Rst = 1'b0;
      Feature_ready = 1'b1;
      idle(1);

      // cube accumulator
      Threshold = 8'd1;
      push(2, 701, 3, 1, 5, 0, 5, 13, 35, 0);
      send(8'd0, 700);
      send(8'd2, 701);
      send(8'd3, 702);
      send(8'd0, 703);
      idle(4);
      chk("final_pcount", 64'(Pulse_count), 1);
      chk("queue_empty", 64'(exp_q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
